// File: rtl/decoder_onehot_seq.sv
// decoder_onehot_seq: registered address-to-one-hot decoder with valid/ready load and sticky range error.
// Define DECODER_SCAN_EN to add the auto-scan mode (SCAN state, dwell counter, o_wrap).
module decoder_onehot_seq #(
  parameter int AW      = 3,
  parameter int NUM_OUT = 6,
  parameter int DWELL   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_mode,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [AW-1:0]      i_a,
  input  logic               i_err_clr,
  output logic [NUM_OUT-1:0] o_y,
  output logic [AW-1:0]      o_idx,
  output logic               o_err,
  output logic               o_wrap
);

  if (NUM_OUT < 2 || NUM_OUT > (1 << AW)) begin : g_bad_num_out
    $error("decoder_onehot_seq: NUM_OUT must lie in 2 .. 2**AW");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("decoder_onehot_seq: DWELL must be at least 1");
  end

  localparam logic [AW-1:0]      LAST_IDX = AW'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] BIT0     = NUM_OUT'(1);

  logic scan_mode;
  logic load;
  logic in_range;

`ifdef DECODER_SCAN_EN
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign scan_mode = i_mode;
`else
  // Without scan support the mode input has no effect on anything.
  assign scan_mode = i_mode & 1'b0;
`endif

  assign o_ready  = i_en & ~scan_mode & ~i_rst;
  assign load     = i_valid & o_ready;
  // One extra bit so the compare also works when NUM_OUT == 2**AW.
  assign in_range = {1'b0, i_a} < (AW+1)'(NUM_OUT);

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_y    <= '0;
      o_idx  <= '0;
      o_err  <= 1'b0;
      o_wrap <= 1'b0;
`ifdef DECODER_SCAN_EN
      state  <= IDLE;
      cnt    <= '0;
`endif
    end else begin
      o_wrap <= 1'b0;
      // Set wins over clear when both happen in the same cycle.
      o_err  <= (load & ~in_range) | (o_err & ~i_err_clr);

      if (!i_en) begin
        o_y   <= '0;
        o_idx <= '0;
`ifdef DECODER_SCAN_EN
        state <= IDLE;
        cnt   <= '0;
`endif
      end else if (load) begin
        if (in_range) begin
          o_y   <= BIT0 << i_a;
          o_idx <= i_a;
`ifdef DECODER_SCAN_EN
          state <= DIRECT;
`endif
        end
      end
`ifdef DECODER_SCAN_EN
      else if (i_mode && state != SCAN) begin
        state <= SCAN;
        o_y   <= BIT0;
        o_idx <= '0;
        cnt   <= '0;
      end else if (state == SCAN) begin
        if (!i_mode) begin
          state <= DIRECT;
        end else if (cnt == CW'(DWELL - 1)) begin
          cnt <= '0;
          if (o_idx == LAST_IDX) begin
            o_idx  <= '0;
            o_y    <= BIT0;
            o_wrap <= 1'b1;
          end else begin
            o_idx <= o_idx + AW'(1);
            o_y   <= o_y << 1;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Self-checking bench for decoder_onehot_seq: elapsed-time behavioural model compared every cycle,
// plus hand-computed directed expectations. Follows the DUT build via DECODER_SCAN_EN.
module tb_decoder_onehot_seq;

  localparam int AW      = 3;
  localparam int NUM_OUT = 6;
  localparam int DWELL   = 4;
`ifdef DECODER_SCAN_EN
  localparam bit SCAN_BUILD = 1'b1;
`else
  localparam bit SCAN_BUILD = 1'b0;
`endif

  logic               i_clk     = 1'b0;
  logic               i_rst     = 1'b1;
  logic               i_en      = 1'b0;
  logic               i_mode    = 1'b0;
  logic               i_valid   = 1'b0;
  logic               i_err_clr = 1'b0;
  logic [AW-1:0]      i_a       = '0;
  logic               o_ready;
  logic [NUM_OUT-1:0] o_y;
  logic [AW-1:0]      o_idx;
  logic               o_err;
  logic               o_wrap;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  logic [NUM_OUT-1:0] exp_y [NUM_OUT] = '{6'b000001, 6'b000010, 6'b000100,
                                         6'b001000, 6'b010000, 6'b100000};

  always #5 i_clk = ~i_clk;

  decoder_onehot_seq #(.AW(AW), .NUM_OUT(NUM_OUT), .DWELL(DWELL)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_mode    (i_mode),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_a       (i_a),
    .i_err_clr (i_err_clr),
    .o_y       (o_y),
    .o_idx     (o_idx),
    .o_err     (o_err),
    .o_wrap    (o_wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Model: scan position is derived from cycles elapsed since scan entry.
  bit m_scan, m_on, m_err, m_wrap, m_rdy, m_acc;
  int m_t, m_idx;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_scan = 0; m_on = 0; m_err = 0; m_wrap = 0; m_t = 0; m_idx = 0;
    end else begin
      m_rdy  = i_en && !(SCAN_BUILD && i_mode);
      m_acc  = i_valid && m_rdy;
      m_wrap = 0;
      m_err  = (m_acc && i_a >= NUM_OUT) || (m_err && !i_err_clr);
      if (!i_en) begin
        m_scan = 0; m_on = 0; m_idx = 0;
      end else if (m_acc) begin
        if (i_a < NUM_OUT) begin
          m_scan = 0; m_on = 1; m_idx = int'(i_a);
        end
      end else if (SCAN_BUILD && i_mode && !m_scan) begin
        m_scan = 1; m_on = 1; m_idx = 0; m_t = 0;
      end else if (m_scan && !i_mode) begin
        m_scan = 0;
      end else if (m_scan) begin
        m_t++;
        m_idx  = (m_t / DWELL) % NUM_OUT;
        m_wrap = (m_t % (DWELL * NUM_OUT)) == 0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("cyc_y",      32'(o_y),    m_on ? (32'd1 << m_idx) : 32'd0);
      check("cyc_idx",    32'(o_idx),  m_on ? 32'(m_idx) : 32'd0);
      check("cyc_err",    32'(o_err),  32'(m_err));
      check("cyc_wrap",   32'(o_wrap), 32'(m_wrap));
      check("cyc_ready",  32'(o_ready), 32'(i_en && !(SCAN_BUILD && i_mode) && !i_rst));
      check("cyc_onehot", 32'($countones(o_y) <= 1), 32'd1);
    end
  end

  int wraps;

  initial begin
    #2;
    check("rst_y",     32'(o_y),     32'd0);
    check("rst_idx",   32'(o_idx),   32'd0);
    check("rst_err",   32'(o_err),   32'd0);
    check("rst_wrap",  32'(o_wrap),  32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    cmp_en = 1'b1;

    step();
    i_rst = 1'b0;
    i_en  = 1'b1;
    step();
    check("idle_y", 32'(o_y), 32'd0);

    // Back-to-back direct loads.
    i_valid = 1'b1;
    for (int i = 0; i < NUM_OUT; i++) begin
      i_a = AW'(i);
      step();
      check("load_y",   32'(o_y),   32'(exp_y[i]));
      check("load_idx", 32'(o_idx), 32'(i));
    end
    check("load_err", 32'(o_err), 32'd0);

    // Out of range with sticky error.
    i_a = 3'd2; step();
    check("oor_pre_y", 32'(o_y), 32'b000100);
    i_a = 3'd6; step();
    check("oor6_y",   32'(o_y),   32'b000100);
    check("oor6_idx", 32'(o_idx), 32'd2);
    check("oor6_err", 32'(o_err), 32'd1);
    i_a = 3'd7; step();
    check("oor7_y",   32'(o_y),   32'b000100);
    check("oor7_err", 32'(o_err), 32'd1);
    i_a = 3'd6; i_err_clr = 1'b1; step();
    check("set_wins_err", 32'(o_err), 32'd1);
    i_valid = 1'b0; step();
    check("clr_err", 32'(o_err), 32'd0);
    i_err_clr = 1'b0;

`ifdef DECODER_SCAN_EN
    // Scan with DWELL = 4 over 6 outputs: wrap after 24 cycles.
    i_mode = 1'b1;
    #1;
    check("scan_ready", 32'(o_ready), 32'd0);
    step();
    check("scan_entry_y",   32'(o_y),   32'b000001);
    check("scan_entry_idx", 32'(o_idx), 32'd0);
    wraps = 0;
    for (int j = 1; j <= 24; j++) begin
      step();
      if (o_wrap) wraps++;
      if (j == 3) check("scan_dwell_y", 32'(o_y), 32'b000001);
      if (j == 4) check("scan_bit1_y",  32'(o_y), 32'b000010);
    end
    check("scan_wraps",   32'(wraps),  32'd1);
    check("scan_wrap_y",  32'(o_y),    32'b000001);
    check("scan_wrap_pl", 32'(o_wrap), 32'd1);

    step(13);
    check("scan_idx3_y", 32'(o_y), 32'b001000);
    i_mode = 1'b0; step();
    check("hold_y",   32'(o_y),   32'b001000);
    check("hold_idx", 32'(o_idx), 32'd3);
    step();
    check("hold2_y", 32'(o_y), 32'b001000);

    i_mode = 1'b1; step();
    check("reentry_y", 32'(o_y), 32'b000001);
    step(12);
    check("reentry_idx3", 32'(o_idx), 32'd3);
    i_mode = 1'b0; i_valid = 1'b1; i_a = 3'd1; step();
    check("exit_load_y", 32'(o_y), 32'b000010);
    i_valid = 1'b0;
`else
    // Mode is ignored: loads still decode and o_wrap stays low.
    i_mode = 1'b1; i_valid = 1'b1; i_a = 3'd4; step();
    check("nomode_y",     32'(o_y),     32'b010000);
    check("nomode_ready", 32'(o_ready), 32'd1);
    check("nomode_wrap",  32'(o_wrap),  32'd0);
    i_valid = 1'b0;
`endif

    // Enable gating.
    i_en = 1'b0; i_valid = 1'b1; i_a = 3'd2;
    #1;
    check("gate_ready", 32'(o_ready), 32'd0);
    step();
    check("gate_y",   32'(o_y),   32'd0);
    check("gate_idx", 32'(o_idx), 32'd0);
    step();
    check("gate_y2", 32'(o_y), 32'd0);
    i_en = 1'b1; i_valid = 1'b0; i_mode = 1'b0;

    // Async reset mid-operation.
    i_valid = 1'b1; i_a = 3'd7; step();
    i_a = 3'd3; step();
    check("pre_rst_y", 32'(o_y), 32'b001000);
    i_valid = 1'b0; i_mode = 1'b1;
    step(6);
    check("pre_rst_err", 32'(o_err), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_y",     32'(o_y),     32'd0);
    check("async_idx",   32'(o_idx),   32'd0);
    check("async_err",   32'(o_err),   32'd0);
    check("async_wrap",  32'(o_wrap),  32'd0);
    check("async_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    step();
    check("post_rst_y", 32'(o_y), SCAN_BUILD ? 32'b000001 : 32'd0);
    step(3);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
